// File: rtl/vec_packet_gather_pkg.sv
// Shared types, default field widths and width helper for the packet gather block.
package vec_packet_gather_pkg;

  localparam int HDR_W_DEF  = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [HDR_W_DEF-1:0]  header;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } packet_t;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((32'sd1 <<< width) < value) width = width + 32'sd1;
    return width;
  endfunction

endpackage

// File: rtl/vec_packet_gather_arb.sv
// Round-robin lane arbiter: one-hot grant, search starts one past the last accepted lane.
module rr_arbiter
  import vec_packet_gather_pkg::*;
#(
  parameter int NUM_IN = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [NUM_IN-1:0] grant
);

  localparam int IDX_W = (NUM_IN > 1) ? clog2(NUM_IN) : 1;

  logic [IDX_W-1:0] startLane_r;
  logic [IDX_W-1:0] grantIdx_s;
  logic             found_s;

  // Priority search over lanes in rotated order, starting at startLane_r.
  always_comb begin
    int   cand;
    logic hit;
    grant      = '0;
    grantIdx_s = '0;
    found_s    = 1'b0;
    cand       = 0;
    hit        = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = int'(startLane_r) + k;
      cand = (cand >= NUM_IN) ? cand - NUM_IN : cand;
      for (int i = 0; i < NUM_IN; i++) begin
        hit        = req[i] && !found_s && (i == cand);
        grant[i]   = grant[i] | hit;
        grantIdx_s = hit ? IDX_W'(i) : grantIdx_s;
        found_s    = found_s | hit;
      end
    end
  end

  // Rotation pointer moves only when the granted packet was actually taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      startLane_r <= '0;
    end else if (advance) begin
      startLane_r <= (int'(grantIdx_s) == NUM_IN - 1) ? '0 : grantIdx_s + 1'b1;
    end else begin
      startLane_r <= startLane_r;
    end
  end

endmodule

// File: rtl/vec_packet_gather.sv
// Gathers packets from several lanes into a circular buffer and releases them as
// fixed-size batches, or as a partial batch after an idle timeout.
module vec_packet_gather
  import vec_packet_gather_pkg::*;
#(
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 4,
  parameter int DEPTH   = 8,
  parameter int HDR_W   = HDR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           io_inPacket_tx_valid,
  output logic [NUM_IN-1:0]           io_inPacket_tx_ready,
  input  logic [NUM_IN*HDR_W-1:0]     io_inPacket_tx_header,
  input  logic [NUM_IN*ADDR_W-1:0]    io_inPacket_tx_addr,
  input  logic [NUM_IN*DATA_W-1:0]    io_inPacket_tx_data,
  output logic                        io_outPacket_rx_valid,
  input  logic                        io_outPacket_rx_ready,
  output logic [NUM_OUT*HDR_W-1:0]    io_outPacket_rx_header,
  output logic [NUM_OUT*ADDR_W-1:0]   io_outPacket_rx_addr,
  output logic [NUM_OUT*DATA_W-1:0]   io_outPacket_rx_data,
  output logic [clog2(NUM_OUT+1)-1:0] io_outPacket_rx_count
);

  localparam int CNT_W = clog2(NUM_OUT + 1);
  localparam int PTR_W = clog2(DEPTH);
  localparam int OCC_W = clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] NUM_OUT_C = OCC_W'(NUM_OUT);
  localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);

  logic [HDR_W-1:0]  hdrMem_r  [DEPTH];
  logic [ADDR_W-1:0] addrMem_r [DEPTH];
  logic [DATA_W-1:0] dataMem_r [DEPTH];

  logic [PTR_W-1:0]  head_r, tail_r;
  logic [OCC_W-1:0]  occ_r;
  logic [7:0]        idle_r;
  logic              held_r;
  logic [CNT_W-1:0]  heldCnt_r;

  logic [NUM_IN-1:0] grant_s;
  logic              push_s, fire_s, release_s, outValid_s;
  logic [CNT_W-1:0]  availCnt_s, outCnt_s;
  logic [HDR_W-1:0]  pushHdr_s;
  logic [ADDR_W-1:0] pushAddr_s;
  logic [DATA_W-1:0] pushData_s;

  rr_arbiter #(.NUM_IN(NUM_IN)) uArb (
    .clock   (clock),
    .reset   (reset),
    .req     (io_inPacket_tx_valid),
    .advance (push_s),
    .grant   (grant_s)
  );

  // Ready is also forced low while reset is held, since grant follows valid combinationally.
  assign io_inPacket_tx_ready = (reset && (occ_r < DEPTH_C)) ? grant_s : '0;
  assign push_s     = |(io_inPacket_tx_valid & io_inPacket_tx_ready);
  assign availCnt_s = (occ_r >= NUM_OUT_C) ? CNT_W'(NUM_OUT) : CNT_W'(occ_r);
  assign release_s  = (occ_r >= NUM_OUT_C) || ((occ_r != '0) && (idle_r == TIMEOUT_C));
  assign fire_s     = outValid_s && io_outPacket_rx_ready;
  assign io_outPacket_rx_valid = outValid_s;
  assign io_outPacket_rx_count = outCnt_s;

  // Mux the granted lane's fields onto the write port.
  always_comb begin
    pushHdr_s  = '0;
    pushAddr_s = '0;
    pushData_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pushHdr_s  = pushHdr_s  | ({HDR_W{grant_s[i]}}  & io_inPacket_tx_header[i*HDR_W +: HDR_W]);
      pushAddr_s = pushAddr_s | ({ADDR_W{grant_s[i]}} & io_inPacket_tx_addr[i*ADDR_W +: ADDR_W]);
      pushData_s = pushData_s | ({DATA_W{grant_s[i]}} & io_inPacket_tx_data[i*DATA_W +: DATA_W]);
    end
  end

  // A presented batch keeps its count frozen so late arrivals cannot join it.
  always_comb begin
    if (held_r) begin
      outValid_s = 1'b1;
      outCnt_s   = heldCnt_r;
    end else if (release_s) begin
      outValid_s = 1'b1;
      outCnt_s   = availCnt_s;
    end else begin
      outValid_s = 1'b0;
      outCnt_s   = '0;
    end
  end

  // Present the oldest entries in slot order; unpopulated slots read as zero.
  always_comb begin
    logic [PTR_W-1:0] rdPtr;
    rdPtr                  = head_r;
    io_outPacket_rx_header = '0;
    io_outPacket_rx_addr   = '0;
    io_outPacket_rx_data   = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      rdPtr = head_r + PTR_W'(j);
      if (j < int'(outCnt_s)) begin
        io_outPacket_rx_header[j*HDR_W +: HDR_W]  = hdrMem_r[rdPtr];
        io_outPacket_rx_addr[j*ADDR_W +: ADDR_W]  = addrMem_r[rdPtr];
        io_outPacket_rx_data[j*DATA_W +: DATA_W]  = dataMem_r[rdPtr];
      end else begin
        io_outPacket_rx_header[j*HDR_W +: HDR_W]  = '0;
        io_outPacket_rx_addr[j*ADDR_W +: ADDR_W]  = '0;
        io_outPacket_rx_data[j*DATA_W +: DATA_W]  = '0;
      end
    end
  end

  // Packet storage, written at the tail on each accepted push.
  always_ff @(posedge clock) begin
    if (push_s) begin
      hdrMem_r[tail_r]  <= pushHdr_s;
      addrMem_r[tail_r] <= pushAddr_s;
      dataMem_r[tail_r] <= pushData_s;
    end
  end

  // Occupancy and circular pointers; push and pop may land in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_r  <= '0;
      head_r <= '0;
      tail_r <= '0;
    end else begin
      occ_r  <= occ_r + OCC_W'(push_s) - (fire_s ? OCC_W'(outCnt_s) : '0);
      tail_r <= push_s ? tail_r + 1'b1 : tail_r;
      head_r <= fire_s ? head_r + PTR_W'(outCnt_s) : head_r;
    end
  end

  // Idle timer (not cleared by pushes) and batch-hold state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_r    <= '0;
      held_r    <= 1'b0;
      heldCnt_r <= '0;
    end else begin
      if (fire_s || (occ_r == '0)) begin
        idle_r <= '0;
      end else if (idle_r < TIMEOUT_C) begin
        idle_r <= idle_r + 8'd1;
      end else begin
        idle_r <= idle_r;
      end
      held_r    <= outValid_s && !fire_s;
      heldCnt_r <= outCnt_s;
    end
  end

endmodule

// File: tb/tb_vec_packet_gather.sv
// Scoreboard bench for vec_packet_gather at default parameters.
module tb_vec_packet_gather;
  import vec_packet_gather_pkg::*;

  localparam int NUM_IN  = 3;
  localparam int NUM_OUT = 4;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;
  localparam int HW = 16;
  localparam int AW = 16;
  localparam int DW = 32;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NUM_IN-1:0]      inValid;
  logic [NUM_IN-1:0]      inReady;
  logic [NUM_IN*HW-1:0]   inHdr;
  logic [NUM_IN*AW-1:0]   inAddr;
  logic [NUM_IN*DW-1:0]   inData;
  logic                   outValid;
  logic                   outReady;
  logic [NUM_OUT*HW-1:0]  outHdr;
  logic [NUM_OUT*AW-1:0]  outAddr;
  logic [NUM_OUT*DW-1:0]  outData;
  logic [2:0]             outCount;

  int      compared   = 0;
  int      mismatched = 0;
  packet_t sbQ[$];
  packet_t lanePkt [NUM_IN];
  int      mOcc, mIdle, mPtr, mHeldCnt;
  bit      mHeld;
  int      riseAt;

  vec_packet_gather #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH),
    .HDR_W(HW), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_inPacket_tx_valid   (inValid),
    .io_inPacket_tx_ready   (inReady),
    .io_inPacket_tx_header  (inHdr),
    .io_inPacket_tx_addr    (inAddr),
    .io_inPacket_tx_data    (inData),
    .io_outPacket_rx_valid  (outValid),
    .io_outPacket_rx_ready  (outReady),
    .io_outPacket_rx_header (outHdr),
    .io_outPacket_rx_addr   (outAddr),
    .io_outPacket_rx_data   (outData),
    .io_outPacket_rx_count  (outCount)
  );

  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setLane(input int i, input bit v, input int n);
    lanePkt[i].header = 16'hA000 | 16'(n);
    lanePkt[i].addr   = 16'h0100 | 16'(n);
    lanePkt[i].data   = 32'(n);
    inValid[i]           = v;
    inHdr[i*HW +: HW]    = lanePkt[i].header;
    inAddr[i*AW +: AW]   = lanePkt[i].addr;
    inData[i*DW +: DW]   = lanePkt[i].data;
  endtask

  task automatic clearLanes();
    inValid = '0;
  endtask

  // Called at a falling edge; checks outputs against the model, then advances one cycle.
  task automatic tick();
    int                g;
    logic [NUM_IN-1:0] expReady;
    bit                expValid, push, fire;
    int                expCnt;
    packet_t           e;
    #1;
    g = -1;
    for (int k = 0; k < NUM_IN; k++) begin
      int lane = (mPtr + k) % NUM_IN;
      if (g < 0 && inValid[lane]) g = lane;
    end
    expReady = '0;
    if (g >= 0 && mOcc < DEPTH) expReady[g] = 1'b1;
    expValid = mHeld || (mOcc >= NUM_OUT) || (mOcc > 0 && mIdle == TIMEOUT);
    if (mHeld) expCnt = mHeldCnt;
    else if (expValid) expCnt = (mOcc < NUM_OUT) ? mOcc : NUM_OUT;
    else expCnt = 0;
    checkEq("ready", inReady, expReady);
    checkEq("valid", outValid, expValid);
    checkEq("count", outCount, expCnt);
    for (int j = 0; j < NUM_OUT; j++) begin
      e = (j < expCnt) ? sbQ[j] : '0;
      checkEq($sformatf("slot%0d_hdr", j),  outHdr[j*HW +: HW],  e.header);
      checkEq($sformatf("slot%0d_addr", j), outAddr[j*AW +: AW], e.addr);
      checkEq($sformatf("slot%0d_data", j), outData[j*DW +: DW], e.data);
    end
    push = (expReady != '0);
    fire = expValid && outReady;
    @(posedge clock);
    if (fire) repeat (expCnt) void'(sbQ.pop_front());
    if (push) begin
      sbQ.push_back(lanePkt[g]);
      mPtr = (g + 1) % NUM_IN;
    end
    if (fire || mOcc == 0) mIdle = 0;
    else if (mIdle < TIMEOUT) mIdle = mIdle + 1;
    mOcc = mOcc + (push ? 1 : 0) - (fire ? expCnt : 0);
    if (!mHeld) mHeldCnt = expCnt;
    mHeld = expValid && !fire;
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkEq("rst_valid", outValid, 64'd0);
    checkEq("rst_count", outCount, 64'd0);
    checkEq("rst_ready", inReady, 64'd0);
    checkEq("rst_fields", 64'(|{outHdr, outAddr, outData}), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    mOcc = 0; mIdle = 0; mPtr = 0; mHeld = 1'b0; mHeldCnt = 0;
    sbQ.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; outReady = 1'b0;
    inValid = '0; inHdr = '0; inAddr = '0; inData = '0;
    doReset();

    // Four consecutive pushes on lane 0 form a full batch.
    outReady = 1'b1;
    for (int n = 1; n <= 4; n++) begin setLane(0, 1'b1, n); tick(); end
    clearLanes();
    #1;
    checkEq("t1_valid", outValid, 64'd1);
    checkEq("t1_count", outCount, 64'd4);
    for (int j = 0; j < 4; j++) checkEq("t1_slot_data", outData[j*DW +: DW], 64'(j + 1));
    tick();

    // All lanes requesting: grants rotate 0,1,2.
    doReset();
    outReady = 1'b1;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < NUM_IN; i++) setLane(i, 1'b1, 16 + c * 3 + i);
      #1;
      checkEq("t2_grant", inReady, 64'd1 << (c % 3));
      tick();
    end
    clearLanes();
    repeat (20) tick();

    // Single packet released only after the idle timeout.
    doReset();
    outReady = 1'b0;
    setLane(0, 1'b1, 8'h33); tick(); clearLanes();
    riseAt = 0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (riseAt == 0 && outValid) riseAt = i;
      tick();
    end
    checkEq("t3_rise_cycle", riseAt, 64'd16);
    outReady = 1'b1;
    repeat (3) tick();

    // Backpressure fills the buffer; then lane 1 alone while draining.
    doReset();
    outReady = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NUM_IN; i++) setLane(i, 1'b1, 64 + c * 3 + i);
      if (c >= 8) begin
        #1;
        checkEq("t4_full_ready", inReady, 64'd0);
      end
      tick();
    end
    checkEq("t4_slot0", outData[0*DW +: DW], 64'd64);
    checkEq("t4_slot1", outData[1*DW +: DW], 64'd68);
    checkEq("t4_slot2", outData[2*DW +: DW], 64'd72);
    checkEq("t4_slot3", outData[3*DW +: DW], 64'd73);
    clearLanes();
    setLane(1, 1'b1, 8'h99);
    outReady = 1'b1;
    #1;
    checkEq("t5_fire_ready", inReady, 64'd0);
    checkEq("t5_fire_count", outCount, 64'd4);
    tick();
    outReady = 1'b0;
    #1;
    checkEq("t5_next_ready", inReady, 64'd2);
    tick();
    clearLanes();
    #1;
    checkEq("t5_second_count", outCount, 64'd4);
    checkEq("t5_second_slot0", outData[0*DW +: DW], 64'd77);
    outReady = 1'b1;
    repeat (20) tick();

    // Reset mid-batch discards contents; only new packets appear afterwards.
    doReset();
    outReady = 1'b0;
    for (int c = 0; c < 6; c++) begin setLane(0, 1'b1, c + 1); tick(); end
    setLane(0, 1'b1, 7);
    doReset();
    clearLanes();
    outReady = 1'b1;
    setLane(0, 1'b1, 8'h51); tick();
    setLane(0, 1'b1, 8'h52); tick();
    clearLanes();
    riseAt = 0;
    for (int i = 1; i <= 25; i++) begin
      #1;
      if (riseAt == 0 && outValid) begin
        riseAt = i;
        checkEq("t6_count", outCount, 64'd2);
        checkEq("t6_slot0", outData[0*DW +: DW], 64'h51);
        checkEq("t6_slot1", outData[1*DW +: DW], 64'h52);
      end
      tick();
    end
    checkEq("t6_rise_cycle", riseAt, 64'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
